dnn_dot_accel: RTL and testbench



---
 rtl/dnn_dot_accel.sv | 180 ++++++++++++++++++
 tb/tb_dnn_dot_accel.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dnn_dot_accel.sv
// Single-neuron fully connected accelerator: act(bias + sum w[i]*x[i]) in signed Q16.16.
// CPU programs it over an Avalon-MM slave; operands and result move over an Avalon-MM master.
module dnn_dot_accel #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              slave_waitrequest,
    input  logic [3:0]        slave_address,
    input  logic              slave_read,
    output logic [31:0]       slave_readdata,
    input  logic              slave_write,
    input  logic [31:0]       slave_writedata,
    input  logic              master_waitrequest,
    output logic [ADDR_W-1:0] master_address,
    output logic              master_read,
    input  logic [31:0]       master_readdata,
    input  logic              master_readdatavalid,
    output logic              master_write,
    output logic [31:0]       master_writedata
);

    typedef enum logic [3:0] {
        StIdle, StRdB, StWtB, StRdW, StWtW, StRdX, StWtX, StMac, StWr
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  bias_addr_q, wbase_q, xbase_q, out_addr_q;
    logic [LEN_W-1:0]   n_q;
    logic               relu_q;
    logic [31:0]        readdata_q;
    logic [31:0]        acc_q, acc_d;
    logic [31:0]        w_q, w_d;
    logic [31:0]        x_q, x_d;
    logic [LEN_W-1:0]   i_q, i_d;

    logic               busy, wr_en, rd_en, start;
    logic [31:0]        rd_mux;
    logic signed [63:0] prod;
    logic [ADDR_W-1:0]  idx_off;
    logic [LEN_W-1:0]   i_inc;
    logic               unused_bits;

    // Busy accesses are stalled, not dropped, so they are serviced once IDLE is reached.
    assign busy              = (state_q != StIdle);
    assign slave_waitrequest = busy && (slave_read || slave_write);
    assign wr_en             = !busy && slave_write;
    assign rd_en             = !busy && slave_read;
    assign start             = wr_en && (slave_address == 4'd0);
    assign slave_readdata    = readdata_q;

    assign prod    = $signed(w_q) * $signed(x_q);
    assign idx_off = ADDR_W'(i_q) << 2;
    assign i_inc   = i_q + LEN_W'(1);

    assign unused_bits = ^{slave_writedata[31:LEN_W], prod[63:48], prod[15:0]};

    always_comb begin
        rd_mux = '0;
        case (slave_address)
            4'd1:    rd_mux = 32'(bias_addr_q);
            4'd2:    rd_mux = 32'(wbase_q);
            4'd3:    rd_mux = 32'(xbase_q);
            4'd4:    rd_mux = 32'(out_addr_q);
            4'd5:    rd_mux = 32'(n_q);
            4'd7:    rd_mux = {31'd0, relu_q};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_addr_q <= '0;
            wbase_q     <= '0;
            xbase_q     <= '0;
            out_addr_q  <= '0;
            n_q         <= '0;
            relu_q      <= 1'b0;
            readdata_q  <= '0;
        end else begin
            if (rd_en) begin
                readdata_q <= rd_mux;
            end
            if (wr_en) begin
                case (slave_address)
                    4'd1:    bias_addr_q <= slave_writedata[ADDR_W-1:0];
                    4'd2:    wbase_q     <= slave_writedata[ADDR_W-1:0];
                    4'd3:    xbase_q     <= slave_writedata[ADDR_W-1:0];
                    4'd4:    out_addr_q  <= slave_writedata[ADDR_W-1:0];
                    4'd5:    n_q         <= slave_writedata[LEN_W-1:0];
                    4'd7:    relu_q      <= slave_writedata[0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            w_q     <= '0;
            x_q     <= '0;
            i_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            w_q     <= w_d;
            x_q     <= x_d;
            i_q     <= i_d;
        end
    end

    // Master outputs are decoded from state so they stay stable while stalled.
    always_comb begin
        state_d          = state_q;
        acc_d            = acc_q;
        w_d              = w_q;
        x_d              = x_q;
        i_d              = i_q;
        master_read      = 1'b0;
        master_write     = 1'b0;
        master_address   = '0;
        master_writedata = '0;
        case (state_q)
            StIdle: begin
                if (start) state_d = StRdB;
            end
            StRdB: begin
                master_read    = 1'b1;
                master_address = bias_addr_q;
                if (!master_waitrequest) state_d = StWtB;
            end
            StWtB: begin
                if (master_readdatavalid) begin
                    acc_d   = master_readdata;
                    i_d     = '0;
                    state_d = (n_q == '0) ? StWr : StRdW;
                end
            end
            StRdW: begin
                master_read    = 1'b1;
                master_address = wbase_q + idx_off;
                if (!master_waitrequest) state_d = StWtW;
            end
            StWtW: begin
                if (master_readdatavalid) begin
                    w_d     = master_readdata;
                    state_d = StRdX;
                end
            end
            StRdX: begin
                master_read    = 1'b1;
                master_address = xbase_q + idx_off;
                if (!master_waitrequest) state_d = StWtX;
            end
            StWtX: begin
                if (master_readdatavalid) begin
                    x_d     = master_readdata;
                    state_d = StMac;
                end
            end
            StMac: begin
                // Taking prod[47:16] truncates toward minus infinity; the sum wraps.
                acc_d   = acc_q + prod[47:16];
                i_d     = i_inc;
                state_d = (i_inc == n_q) ? StWr : StRdW;
            end
            StWr: begin
                master_write     = 1'b1;
                master_address   = out_addr_q;
                master_writedata = (relu_q && acc_q[31]) ? 32'd0 : acc_q;
                if (!master_waitrequest) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_dnn_dot_accel.sv
// Directed bench for dnn_dot_accel with an Avalon-MM memory model on the master side.
module tb_dnn_dot_accel;

    localparam int ADDR_W = 32;
    localparam int LEN_W  = 16;

    logic              clk;
    logic              rst_n;
    logic              slave_waitrequest;
    logic [3:0]        slave_address;
    logic              slave_read;
    logic [31:0]       slave_readdata;
    logic              slave_write;
    logic [31:0]       slave_writedata;
    logic              master_waitrequest;
    logic [ADDR_W-1:0] master_address;
    logic              master_read;
    logic [31:0]       master_readdata;
    logic              master_readdatavalid;
    logic              master_write;
    logic [31:0]       master_writedata;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          read_count = 0;
    int          write_count = 0;
    int          last_wr_cyc = 0;
    bit          bp_mode = 0;
    int          fixed_lat = 1;
    logic [31:0] mem [0:1023];

    dnn_dot_accel #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .slave_waitrequest    (slave_waitrequest),
        .slave_address        (slave_address),
        .slave_read           (slave_read),
        .slave_readdata       (slave_readdata),
        .slave_write          (slave_write),
        .slave_writedata      (slave_writedata),
        .master_waitrequest   (master_waitrequest),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master_write         (master_write),
        .master_writedata     (master_writedata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory model: decides waitrequest/readdatavalid at each falling edge.
    initial begin
        bit          in_req;
        int          stall;
        int          pend;
        logic [31:0] pdata, cap_a, cap_d;
        logic        cap_w;
        in_req = 0; stall = 0; pend = 0; pdata = '0;
        cap_a = '0; cap_d = '0; cap_w = 1'b0;
        master_waitrequest   = 1'b0;
        master_readdatavalid = 1'b0;
        master_readdata      = '0;
        forever begin
            @(negedge clk);
            cyc++;
            master_readdatavalid = 1'b0;
            master_waitrequest   = 1'b0;
            if (!rst_n) begin
                in_req = 0;
                pend   = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        master_readdatavalid = 1'b1;
                        master_readdata      = pdata;
                    end
                end
                if (master_read || master_write) begin
                    if (!in_req) begin
                        in_req = 1;
                        stall  = bp_mode ? int'($urandom_range(5, 1)) : 0;
                        cap_a  = master_address;
                        cap_w  = master_write;
                        cap_d  = master_writedata;
                    end else begin
                        chk("stall_addr", master_address, cap_a);
                        chk("stall_kind", 32'(master_write), 32'(cap_w));
                        if (cap_w) chk("stall_wdata", master_writedata, cap_d);
                    end
                    if (stall > 0) begin
                        master_waitrequest = 1'b1;
                        stall--;
                    end else begin
                        in_req = 0;
                        if (master_write) begin
                            mem[master_address[11:2]] = master_writedata;
                            write_count++;
                            last_wr_cyc = cyc;
                        end else begin
                            read_count++;
                            pdata = mem[master_address[11:2]];
                            pend  = bp_mode ? int'($urandom_range(8, 1)) : fixed_lat;
                        end
                    end
                end
            end
        end
    end

    task automatic slave_wr(input logic [3:0] a, input logic [31:0] d, output int acc_cyc);
        int n;
        n = 0;
        @(negedge clk);
        slave_address = a; slave_writedata = d; slave_write = 1'b1;
        #1;
        while (slave_waitrequest && n < 2000) begin
            @(negedge clk); #1; n++;
        end
        chk("slave_wr_bound", 32'(n < 2000), 32'd1);
        acc_cyc = cyc;
        @(posedge clk); #1;
        slave_write = 1'b0;
    endtask

    task automatic slave_rd(input logic [3:0] a, output logic [31:0] d, output int acc_cyc);
        int n;
        n = 0;
        @(negedge clk);
        slave_address = a; slave_read = 1'b1;
        #1;
        while (slave_waitrequest && n < 2000) begin
            @(negedge clk); #1; n++;
        end
        chk("slave_rd_bound", 32'(n < 2000), 32'd1);
        acc_cyc = cyc;
        @(posedge clk); #1;
        slave_read = 1'b0;
        d = slave_readdata;
    endtask

    task automatic prog(input logic [31:0] wb, input logic [31:0] n, input logic [31:0] relu);
        int c;
        slave_wr(4'd1, 32'h100, c);
        slave_wr(4'd2, wb, c);
        slave_wr(4'd3, 32'h300, c);
        slave_wr(4'd4, 32'h400, c);
        slave_wr(4'd5, n, c);
        slave_wr(4'd7, relu, c);
    endtask

    // Start, then read word 0, which stalls until the run has finished.
    task automatic do_run(output logic [31:0] rd0, output int sc, output int rc);
        read_count  = 0;
        write_count = 0;
        slave_wr(4'd0, 32'd1, sc);
        slave_rd(4'd0, rd0, rc);
    endtask

    task automatic load_basic();
        mem[32'h100 >> 2] = 32'h0001_0000;
        mem[32'h200 >> 2] = 32'h0002_0000;
        mem[32'h204 >> 2] = 32'h0000_8000;
        mem[32'h300 >> 2] = 32'h0003_0000;
        mem[32'h304 >> 2] = 32'h0004_0000;
    endtask

    initial begin
        logic [31:0] rd;
        int          sc, rc, c, n;
        for (int k = 0; k < 1024; k++) mem[k] = 32'hDEAD_0000 + k;
        slave_address = '0; slave_read = 1'b0; slave_write = 1'b0; slave_writedata = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_master_read", 32'(master_read), 32'd0);
        chk("rst_master_write", 32'(master_write), 32'd0);
        chk("rst_master_address", master_address, 32'd0);
        chk("rst_master_wdata", master_writedata, 32'd0);
        chk("rst_slave_wait", 32'(slave_waitrequest), 32'd0);
        chk("rst_slave_rdata", slave_readdata, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Register file
        slave_wr(4'd1, 32'h0000_0100, c);
        slave_wr(4'd5, 32'hABCD_1234, c);
        slave_wr(4'd6, 32'hDEAD_BEEF, c);
        slave_rd(4'd1, rd, c);  chk("reg_bias", rd, 32'h0000_0100);
        slave_rd(4'd5, rd, c);  chk("reg_n_zext", rd, 32'h0000_1234);
        slave_rd(4'd6, rd, c);  chk("reg_unused", rd, 32'd0);

        // Basic run, zero-wait memory
        load_basic();
        prog(32'h200, 32'd2, 32'd0);
        do_run(rd, sc, rc);
        chk("basic_rd0", rd, 32'd0);
        chk("basic_result", mem[32'h400 >> 2], 32'h0009_0000);
        chk("basic_reads", 32'(read_count), 32'd5);
        chk("basic_writes", 32'(write_count), 32'd1);
        chk("basic_cycles", 32'(last_wr_cyc - sc), 32'd13);
        chk("basic_rd0_after_wr", 32'(rc - last_wr_cyc), 32'd1);

        // ReLU clamp
        mem[32'h100 >> 2] = 32'hFFFF_0000;
        mem[32'h200 >> 2] = 32'h0001_0000;
        mem[32'h300 >> 2] = 32'hFFFE_0000;
        prog(32'h200, 32'd1, 32'd1);
        do_run(rd, sc, rc);
        chk("relu_on", mem[32'h400 >> 2], 32'h0000_0000);
        slave_wr(4'd7, 32'd0, c);
        do_run(rd, sc, rc);
        chk("relu_off", mem[32'h400 >> 2], 32'hFFFD_0000);

        // N = 0: bias passes straight through
        mem[32'h100 >> 2] = 32'h1234_5678;
        slave_wr(4'd5, 32'd0, c);
        do_run(rd, sc, rc);
        chk("n0_result", mem[32'h400 >> 2], 32'h1234_5678);
        chk("n0_reads", 32'(read_count), 32'd1);
        chk("n0_writes", 32'(write_count), 32'd1);
        chk("n0_cycles", 32'(last_wr_cyc - sc), 32'd3);

        // Truncation toward minus infinity, then 32-bit wrap
        mem[32'h100 >> 2] = 32'h0000_0000;
        mem[32'h200 >> 2] = 32'h0000_0001;
        mem[32'h300 >> 2] = 32'hFFFF_FFFF;
        slave_wr(4'd5, 32'd1, c);
        do_run(rd, sc, rc);
        chk("trunc_floor", mem[32'h400 >> 2], 32'hFFFF_FFFF);
        mem[32'h100 >> 2] = 32'h7FFF_0000;
        mem[32'h200 >> 2] = 32'h0001_0000;
        mem[32'h300 >> 2] = 32'h0001_0000;
        do_run(rd, sc, rc);
        chk("acc_wrap", mem[32'h400 >> 2], 32'h8000_0000);

        // Backpressure: random waitrequest and readdatavalid latency
        bp_mode = 1;
        for (int r = 0; r < 3; r++) begin
            load_basic();
            mem[32'h400 >> 2] = 32'h0;
            prog(32'h200, 32'd2, 32'd0);
            do_run(rd, sc, rc);
            chk("bp_result", mem[32'h400 >> 2], 32'h0009_0000);
            chk("bp_reads", 32'(read_count), 32'd5);
            chk("bp_writes", 32'(write_count), 32'd1);
            chk("bp_rd0", rd, 32'd0);
        end
        bp_mode = 0;

        // Busy stall: reprogramming wbase mid-run waits for IDLE
        load_basic();
        mem[32'h500 >> 2] = 32'h0001_0000;
        mem[32'h504 >> 2] = 32'h0001_0000;
        read_count  = 0;
        write_count = 0;
        slave_wr(4'd0, 32'd1, sc);
        slave_wr(4'd2, 32'h500, c);
        chk("busy_wr_after_idle", 32'(c - last_wr_cyc), 32'd1);
        chk("busy_result", mem[32'h400 >> 2], 32'h0009_0000);
        slave_rd(4'd2, rd, c);
        chk("busy_new_wbase", rd, 32'h0000_0500);
        do_run(rd, sc, rc);
        chk("busy_second_run", mem[32'h400 >> 2], 32'h0008_0000);

        // Reset while waiting for x[0]
        load_basic();
        mem[32'h400 >> 2] = 32'hA5A5_A5A5;
        fixed_lat   = 8;
        slave_wr(4'd2, 32'h200, c);
        read_count  = 0;
        write_count = 0;
        slave_wr(4'd0, 32'd1, sc);
        n = 0;
        while (read_count < 3 && n < 200) begin
            @(negedge clk); #1; n++;
        end
        chk("rst_mid_bound", 32'(n < 200), 32'd1);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_read", 32'(master_read), 32'd0);
        chk("rst_mid_write", 32'(master_write), 32'd0);
        slave_address = 4'd1; slave_read = 1'b1;
        #1;
        chk("rst_mid_idle", 32'(slave_waitrequest), 32'd0);
        slave_read = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        chk("rst_mid_no_write", 32'(write_count), 32'd0);
        chk("rst_mid_out_kept", mem[32'h400 >> 2], 32'hA5A5_A5A5);
        fixed_lat = 1;
        slave_rd(4'd1, rd, c);  chk("rst_reg1", rd, 32'd0);
        slave_rd(4'd2, rd, c);  chk("rst_reg2", rd, 32'd0);
        slave_rd(4'd3, rd, c);  chk("rst_reg3", rd, 32'd0);
        slave_rd(4'd4, rd, c);  chk("rst_reg4", rd, 32'd0);
        slave_rd(4'd5, rd, c);  chk("rst_reg5", rd, 32'd0);
        slave_rd(4'd7, rd, c);  chk("rst_reg7", rd, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
